bram_sample_writer: RTL and testbench

Packs the 16-bit receive sample stream into 32-bit words and writes them into the capture BRAM as a two-half ping-pong buffer. It generates byte addresses in steps of 4, the BRAM write strobes, and per-half completion pulses for the PS-side reader. It sits between the decimated RX sample source and the BRAM port, and gates capture with the same `hab` hold-off used in the RX capture path.

---
 rtl/bram_sample_writer.sv | 125 ++++++++++++
 tb/tb_bram_sample_writer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sample_writer.sv
// Packs pairs of 16-bit RX samples into 32-bit words and writes them into a
// two-half ping-pong capture BRAM, pulsing block_done as each half fills.
module bram_sample_writer #(
    parameter int HALF_WORDS = 2048,
    parameter int HALF_BIT   = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hab,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_din,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic        block_done,
    output logic        bank,
    output logic        overflow
);

    localparam int AW = HALF_BIT + 1;
    localparam logic [HALF_BIT-3:0] LAST_IDX = (HALF_BIT - 2)'(HALF_WORDS - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, WRITE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     din_q, din_d;
    logic            ready_q, ready_d;
    logic            en_q, en_d;
    logic [3:0]      we_q, we_d;
    logic            done_q, done_d;
    logic            bank_q, bank_d;
    logic            ovf_q, ovf_d;
    logic            accept;

    assign accept = s_valid && ready_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        din_d   = din_q;
        en_d    = 1'b0;
        we_d    = 4'h0;
        done_d  = 1'b0;
        bank_d  = bank_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (!hab) state_d = LO;
            end
            LO: begin
                if (hab) begin
                    state_d = IDLE;
                end else if (accept) begin
                    din_d[15:0] = s_data;
                    state_d     = HI;
                end
            end
            HI: begin
                if (hab) begin
                    state_d = IDLE;
                end else if (accept) begin
                    din_d[31:16] = s_data;
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                // Write strobes are registered, so the BRAM sees them one cycle later.
                en_d    = 1'b1;
                we_d    = 4'hF;
                state_d = hab ? IDLE : LO;
                if (s_valid) ovf_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // The address advances on the edge that completes the strobed write.
        if (en_q) begin
            addr_d = addr_q + AW'(4);
            if (addr_q[HALF_BIT-1:2] == LAST_IDX) begin
                done_d = 1'b1;
                bank_d = addr_q[HALF_BIT];
            end
        end

        ready_d = (state_d == LO) || (state_d == HI);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            din_q   <= '0;
            ready_q <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 4'h0;
            done_q  <= 1'b0;
            bank_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ready_q <= ready_d;
            en_q    <= en_d;
            we_q    <= we_d;
            done_q  <= done_d;
            bank_q  <= bank_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s_ready    = ready_q;
    assign bram_addr  = {{(32 - AW){1'b0}}, addr_q};
    assign bram_din   = din_q;
    assign bram_en    = en_q;
    assign bram_we    = we_q;
    assign block_done = done_q;
    assign bank       = bank_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_bram_sample_writer.sv
// Directed bench for bram_sample_writer with a 4-word half so wraps are reachable.
module tb_bram_sample_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hab = 1'b1;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] bram_addr;
    logic [31:0] bram_din;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic        block_done;
    logic        bank;
    logic        overflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] dn_addr[$];
    logic        dn_bank[$];

    bram_sample_writer #(.HALF_WORDS(4), .HALF_BIT(4)) dut (
        .clk(clk), .rst(rst), .hab(hab), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_en(bram_en), .bram_we(bram_we), .block_done(block_done),
        .bank(bank), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bram_en) begin
            wr_addr.push_back(bram_addr);
            wr_data.push_back(bram_din);
        end
        if (block_done) begin
            dn_addr.push_back(bram_addr);
            dn_bank.push_back(bank);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wr_addr.delete(); wr_data.delete(); dn_addr.delete(); dn_bank.delete();
    endtask

    task automatic send(input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (!s_ready) begin
            $display("FAIL send_ready_timeout sample=%h s_ready=%b required 1", d, s_ready);
        end else begin
            pass_cnt++;
            s_valid = 1'b1;
            s_data  = d;
            @(posedge clk);
            #1 s_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        hab = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({bram_addr, bram_din, bram_en, bram_we, block_done, bank, overflow, s_ready} !== 73'd0)
            $display("FAIL reset_outputs addr=%h din=%h en=%b we=%h done=%b bank=%b ovf=%b rdy=%b required all 0",
                     bram_addr, bram_din, bram_en, bram_we, block_done, bank, overflow, s_ready);
        else pass_cnt++;
        hab = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (s_ready !== 1'b1) $display("FAIL reset_leave_idle s_ready=%b required 1", s_ready);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        hab = 1'b0;
        do_reset();
        send(16'h0001);
        send(16'h0002);
        @(negedge clk);
        total_cnt++;
        if (bram_en !== 1'b0) $display("FAIL basic_en_early bram_en=%b required 0", bram_en);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bram_en !== 1'b1 || bram_we !== 4'hF || bram_addr !== 32'd0 || bram_din !== 32'h00020001)
            $display("FAIL basic_write en=%b we=%h addr=%h din=%h required 1 F 0 00020001",
                     bram_en, bram_we, bram_addr, bram_din);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bram_en !== 1'b0 || bram_we !== 4'h0 || bram_addr !== 32'd4 || s_ready !== 1'b1)
            $display("FAIL basic_after en=%b we=%h addr=%h rdy=%b required 0 0 4 1",
                     bram_en, bram_we, bram_addr, s_ready);
        else pass_cnt++;
        $display("test_basic write addr=0 din=00020001");
    endtask

    task automatic test_wrap();
        hab = 1'b0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            send(16'h0100 + 16'(2 * k));
            send(16'h0100 + 16'(2 * k + 1));
        end
        repeat (4) @(negedge clk);
        total_cnt++;
        if (wr_addr.size() != 8) $display("FAIL wrap_count writes=%0d required 8", wr_addr.size());
        else pass_cnt++;
        for (int k = 0; k < 8 && k < wr_addr.size(); k++) begin
            total_cnt++;
            if (wr_addr[k] !== 32'(4 * k) || wr_data[k] !== {16'h0100 + 16'(2 * k + 1), 16'h0100 + 16'(2 * k)})
                $display("FAIL wrap_write[%0d] addr=%h din=%h required %h %h", k, wr_addr[k], wr_data[k],
                         32'(4 * k), {16'h0100 + 16'(2 * k + 1), 16'h0100 + 16'(2 * k)});
            else pass_cnt++;
        end
        total_cnt++;
        if (dn_addr.size() != 2) $display("FAIL wrap_done_count pulses=%0d required 2", dn_addr.size());
        else begin
            if (dn_addr[0] !== 32'd16 || dn_bank[0] !== 1'b0 || dn_addr[1] !== 32'd0 || dn_bank[1] !== 1'b1)
                $display("FAIL wrap_done addr0=%h bank0=%b addr1=%h bank1=%b required 10 0 0 1",
                         dn_addr[0], dn_bank[0], dn_addr[1], dn_bank[1]);
            else pass_cnt++;
        end
        send(16'h0BBB);
        send(16'h0CCC);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (wr_addr.size() != 9 || wr_addr[wr_addr.size() - 1] !== 32'd0 || bank !== 1'b1)
            $display("FAIL wrap_next writes=%0d last_addr=%h bank=%b required 9 0 1",
                     wr_addr.size(), wr_addr[wr_addr.size() - 1], bank);
        else pass_cnt++;
        $display("test_wrap writes=%0d done_pulses=%0d", wr_addr.size(), dn_addr.size());
    endtask

    task automatic test_overflow();
        hab = 1'b0;
        do_reset();
        repeat (2) @(negedge clk);
        total_cnt++;
        if (s_ready !== 1'b1) $display("FAIL ovf_ready s_ready=%b required 1", s_ready);
        else pass_cnt++;
        s_valid = 1'b1;
        s_data  = 16'h0010;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 s_data = 16'h0011 + 16'(i);
            if (i == 1) begin
                total_cnt++;
                if (overflow !== 1'b0) $display("FAIL ovf_before overflow=%b required 0", overflow);
                else pass_cnt++;
            end
            if (i == 2) begin
                total_cnt++;
                if (overflow !== 1'b1) $display("FAIL ovf_set overflow=%b required 1", overflow);
                else pass_cnt++;
            end
        end
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (wr_addr.size() != 2) $display("FAIL ovf_count writes=%0d required 2", wr_addr.size());
        else if (wr_data[0] !== 32'h00110010 || wr_data[1] !== 32'h00140013 || wr_addr[1] !== 32'd4)
            $display("FAIL ovf_data din0=%h din1=%h addr1=%h required 00110010 00140013 4",
                     wr_data[0], wr_data[1], wr_addr[1]);
        else pass_cnt++;
        total_cnt++;
        if (overflow !== 1'b1) $display("FAIL ovf_sticky overflow=%b required 1", overflow);
        else pass_cnt++;
        $display("test_overflow overflow=%b writes=%0d", overflow, wr_addr.size());
    endtask

    task automatic test_hab_hi();
        hab = 1'b0;
        do_reset();
        send(16'h0001);
        send(16'h0002);
        repeat (3) @(negedge clk);
        send(16'hAAAA);
        hab = 1'b1;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (s_ready !== 1'b0 || wr_addr.size() != 1 || bram_addr !== 32'd4)
            $display("FAIL habhi_hold rdy=%b writes=%0d addr=%h required 0 1 4", s_ready, wr_addr.size(), bram_addr);
        else pass_cnt++;
        hab = 1'b0;
        send(16'h0003);
        send(16'h0004);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (wr_addr.size() != 2) $display("FAIL habhi_count writes=%0d required 2", wr_addr.size());
        else if (wr_addr[1] !== 32'd4 || wr_data[1] !== 32'h00040003)
            $display("FAIL habhi_resume addr=%h din=%h required 4 00040003", wr_addr[1], wr_data[1]);
        else pass_cnt++;
        $display("test_hab_hi resumed writes=%0d", wr_addr.size());
    endtask

    task automatic test_hab_write();
        hab = 1'b0;
        do_reset();
        send(16'h0005);
        send(16'h0006);
        hab = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b1;
        s_data = 16'hFFFF;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (wr_addr.size() != 1) $display("FAIL habwr_count writes=%0d required 1", wr_addr.size());
        else if (wr_addr[0] !== 32'd0 || wr_data[0] !== 32'h00060005)
            $display("FAIL habwr_write addr=%h din=%h required 0 00060005", wr_addr[0], wr_data[0]);
        else pass_cnt++;
        total_cnt++;
        if (bram_addr !== 32'd4 || overflow !== 1'b0 || s_ready !== 1'b0)
            $display("FAIL habwr_idle addr=%h ovf=%b rdy=%b required 4 0 0", bram_addr, overflow, s_ready);
        else pass_cnt++;
        s_valid = 1'b0;
        $display("test_hab_write addr=%h overflow=%b", bram_addr, overflow);
    endtask

    task automatic test_rst_mid_write();
        hab = 1'b0;
        do_reset();
        send(16'h0001);
        send(16'h0002);
        repeat (3) @(negedge clk);
        send(16'h0007);
        send(16'h0008);
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bram_en !== 1'b1 || bram_addr !== 32'd4 || overflow !== 1'b1)
            $display("FAIL rstmid_pre en=%b addr=%h ovf=%b required 1 4 1", bram_en, bram_addr, overflow);
        else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        total_cnt++;
        if (bram_en !== 1'b0 || bram_we !== 4'h0 || bram_addr !== 32'd0 || overflow !== 1'b0)
            $display("FAIL rstmid_async en=%b we=%h addr=%h ovf=%b required 0 0 0 0",
                     bram_en, bram_we, bram_addr, overflow);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        wr_addr.delete(); wr_data.delete(); dn_addr.delete(); dn_bank.delete();
        send(16'h0009);
        send(16'h000A);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (wr_addr.size() != 1) $display("FAIL rstmid_count writes=%0d required 1", wr_addr.size());
        else if (wr_addr[0] !== 32'd0 || wr_data[0] !== 32'h000A0009)
            $display("FAIL rstmid_after addr=%h din=%h required 0 000A0009", wr_addr[0], wr_data[0]);
        else pass_cnt++;
        $display("test_rst_mid_write writes=%0d", wr_addr.size());
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_hab_hi();
        test_hab_write();
        test_rst_mid_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d", total_cnt);
        $fatal(1, "timeout");
    end

endmodule
